booth_mult_seq: RTL and testbench

- Iterative signed 32x32 radix-4 Booth multiplier for the multdiv unit.
- Sits directly upstream of the overflow checker. It supplies the 65-bit partial product register, the 32-bit truncated result and the latched operands.
- Takes 16 Booth iterations (one per clock), then pulses a ready flag.

---
 rtl/booth_mult_seq_pkg.sv | 24 ++
 rtl/booth_mult_seq_booth_recoder.sv | 22 ++
 rtl/booth_mult_seq.sv | 116 +++++++++++
 tb/tb_booth_mult_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/booth_mult_seq_pkg.sv
// Shared constants and encodings for the sequential radix-4 Booth multiplier.
package booth_mult_seq_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = WIDTH / 2;
    localparam int AW    = WIDTH + 2;        // accumulator width incl. guard bits
    localparam int PW    = 2 * WIDTH + 3;    // {guard[1:0], upper, lower, booth_bit}

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Select bits are {zero, negate, double}
    typedef enum logic [2:0] {
        PM   = 3'b000,
        P2M  = 3'b001,
        NM   = 3'b010,
        N2M  = 3'b011,
        ZERO = 3'b100
    } booth_sel_e;

endpackage

// File: rtl/booth_mult_seq_booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a {zero, negate, double} select.
module booth_recoder
    import booth_mult_seq_pkg::*;
(
    input  logic [2:0] window_i,
    output logic [2:0] sel_o
);

    // Window-to-select decode
    always_comb begin
        sel_o = ZERO;
        case (window_i)
            3'b000, 3'b111: sel_o = ZERO;
            3'b001, 3'b010: sel_o = PM;
            3'b011:         sel_o = P2M;
            3'b100:         sel_o = N2M;
            3'b101, 3'b110: sel_o = NM;
            default:        sel_o = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative signed 32x32 radix-4 Booth multiplier; 16 iterations then a one-cycle ready pulse.
module booth_mult_seq
    import booth_mult_seq_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ctrl_MULT,
    input  logic [WIDTH-1:0]     data_operandA,
    input  logic [WIDTH-1:0]     data_operandB,
    output logic [WIDTH-1:0]     A_q,
    output logic [WIDTH-1:0]     B_q,
    output logic [2*WIDTH:0]     partial_product_out,
    output logic [WIDTH-1:0]     data_result,
    output logic                 data_resultRDY,
    output logic                 busy
);

    state_e              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [PW-1:0]       prod_q, prod_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;

    logic [2:0]          sel_s;
    logic [AW-1:0]       m_s;
    logic [AW-1:0]       mag_s;
    logic [AW-1:0]       addend_s;
    logic [AW-1:0]       sum_s;
    logic [PW-1:0]       shifted_s;
    logic                start_s;

    booth_recoder u_recoder (
        .window_i (prod_q[2:0]),
        .sel_o    (sel_s)
    );

    // Booth addend selection, accumulate into the upper field, arithmetic shift by two
    always_comb begin
        m_s = {{2{mcand_q[WIDTH-1]}}, mcand_q};
        if (sel_s[0]) begin
            mag_s = {m_s[AW-2:0], 1'b0};
        end else begin
            mag_s = m_s;
        end
        if (sel_s[2]) begin
            addend_s = {AW{1'b0}};
        end else if (sel_s[1]) begin
            addend_s = ~mag_s + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            addend_s = mag_s;
        end
        sum_s     = prod_q[PW-1:WIDTH+1] + addend_s;
        shifted_s = {{2{sum_s[AW-1]}}, sum_s, prod_q[WIDTH:2]};
    end

    assign start_s = ctrl_MULT;

    // Next-state and datapath register update
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_s) begin
                    mcand_d  = data_operandA;
                    mplier_d = data_operandB;
                    prod_d   = {34'b0, data_operandB, 1'b0};
                    count_d  = 4'd0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                prod_d  = shifted_s;
                count_d = count_q + 4'd1;
                if (count_q == 4'(ITERS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            prod_q   <= {PW{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign A_q                 = mcand_q;
    assign B_q                 = mplier_q;
    assign partial_product_out = prod_q[2*WIDTH:0];
    assign data_result         = prod_q[WIDTH:1];
    assign data_resultRDY      = (state_q == DONE);
    assign busy                = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed plus random checks of booth_mult_seq against a plain signed-multiply reference.
module tb_booth_mult_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] A_q;
    logic [31:0] B_q;
    logic [64:0] partial_product_out;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    booth_mult_seq dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .ctrl_MULT           (ctrl_MULT),
        .data_operandA       (data_operandA),
        .data_operandB       (data_operandB),
        .A_q                 (A_q),
        .B_q                 (B_q),
        .partial_product_out (partial_product_out),
        .data_result         (data_result),
        .data_resultRDY      (data_resultRDY),
        .busy                (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return 64'(sa * sb);
    endfunction

    // Present a start on the next rising edge and return 1ns after it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        while (data_resultRDY !== 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = ref_prod(a, b);
        chk({tag, "_lo"},   {32'd0, data_result}, {32'd0, p[31:0]});
        chk({tag, "_hi"},   {32'd0, partial_product_out[64:33]}, {32'd0, p[63:32]});
        chk({tag, "_pp"},   {32'd0, partial_product_out[32:1]}, {32'd0, p[31:0]});
        chk({tag, "_aq"},   {32'd0, A_q}, {32'd0, a});
        chk({tag, "_bq"},   {32'd0, B_q}, {32'd0, b});
    endtask

    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int c;
        start_op(a, b);
        wait_rdy(c);
        chk({tag, "_latency"}, 64'(c), 64'd16);
        check_result(tag, a, b);
    endtask

    initial begin
        int          c;
        int          rdy_seen;
        logic [31:0] ra;
        logic [31:0] rb;

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #12;
        chk("rst_pp",   {63'd0, |partial_product_out}, 64'd0);
        chk("rst_aq",   {32'd0, A_q}, 64'd0);
        chk("rst_bq",   {32'd0, B_q}, 64'd0);
        chk("rst_rdy",  {63'd0, data_resultRDY}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        full_op("m3x5", 32'd3, 32'd5);
        @(posedge clock);
        #1;
        chk("hold_rdy",  {63'd0, data_resultRDY}, 64'd0);
        chk("hold_busy", {63'd0, busy}, 64'd0);
        chk("hold_lo",   {32'd0, data_result}, 64'h0F);

        full_op("m7x6",  32'hFFFFFFF9, 32'd6);
        full_op("mmaxx2", 32'h7FFFFFFF, 32'd2);
        full_op("mminsq", 32'h80000000, 32'h80000000);

        // A second strobe mid-run must not disturb the operation in flight
        start_op(32'd4, 32'd4);
        repeat (4) @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        chk("ign_aq", {32'd0, A_q}, 64'd4);
        wait_rdy(c);
        chk("ign_latency", 64'(c), 64'd11);
        check_result("ign", 32'd4, 32'd4);

        // Reset mid-operation
        start_op(32'd123, 32'd456);
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mrst_pp",   {63'd0, |partial_product_out}, 64'd0);
        chk("mrst_aq",   {32'd0, A_q}, 64'd0);
        chk("mrst_bq",   {32'd0, B_q}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_res",  {32'd0, data_result}, 64'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        chk("mrst_no_rdy", 64'(rdy_seen), 64'd0);
        full_op("post_rst", 32'hFFFFFF85, 32'd77);

        // Back-to-back: restart straight out of DONE
        full_op("b2b_first", 32'd3, 32'd5);
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_rdy(c);
        chk("b2b_latency", 64'(c), 64'd16);
        check_result("b2b", 32'hFFFFFFFF, 32'hFFFFFFFF);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h80000000;
            if (i == 1) rb = 32'h80000000;
            if (i == 2) rb = 32'h7FFFFFFF;
            full_op("rand", ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
